// File: rtl/sel_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sel_out_fifo
// Brief    : Output FIFO for the byte selector. Lane-masks each incoming
//            result word, buffers it, and presents it first-word-fall-through
//            over a valid/ready handshake with occupancy and sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module sel_out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 FLUSH,
  input  logic                 IN_VALID,
  input  logic [WIDTH-1:0]     IN_DATA,
  input  logic [WIDTH/8-1:0]   IN_BE,
  output logic                 IN_READY,
  output logic                 OUT_VALID,
  output logic [WIDTH-1:0]     OUT_DATA,
  output logic [WIDTH/8-1:0]   OUT_BE,
  input  logic                 OUT_READY,
  output logic [AW:0]          COUNT,
  output logic                 FULL,
  output logic                 EMPTY,
  output logic                 OVERFLOW
);

  localparam int          C_NB    = WIDTH / 8;
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ONE   = (AW+1)'(1);

  // Storage has no reset: entries are only visible through valid pointers.
  logic [WIDTH-1:0] mem_q    [DEPTH];
  logic [C_NB-1:0]  be_mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_masked;

  assign w_full  = (count_q == C_DEPTH);
  assign w_empty = (count_q == '0);

  // Full blocks a push even when a pop frees a slot in the same cycle, so
  // IN_READY depends on registered state only. Flush discards both sides.
  assign w_push = IN_VALID && !w_full && !FLUSH;
  assign w_pop  = OUT_READY && !w_empty && !FLUSH;

  // Zero every byte lane whose enable is low before it is stored.
  for (genvar i = 0; i < C_NB; i++) begin : g_lane
    assign w_masked[8*i +: 8] = IN_BE[i] ? IN_DATA[8*i +: 8] : 8'h00;
  end

  // Write the masked word and its lane enables into the tail slot.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      mem_q[wr_ptr_q]    <= w_masked;
      be_mem_q[wr_ptr_q] <= IN_BE;
    end
  end

  // Next-state for pointers, occupancy and sticky overflow; flush wins.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + C_ONE;
        2'b01:   count_d = count_q - C_ONE;
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (IN_VALID & w_full);
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Head entry is shown only while non-empty; otherwise outputs read zero.
  always_comb begin
    OUT_DATA = '0;
    OUT_BE   = '0;
    if (!w_empty) begin
      OUT_DATA = mem_q[rd_ptr_q];
      OUT_BE   = be_mem_q[rd_ptr_q];
    end
  end

  assign IN_READY  = !w_full;
  assign OUT_VALID = !w_empty;
  assign COUNT     = count_q;
  assign FULL      = w_full;
  assign EMPTY     = w_empty;
  assign OVERFLOW  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sel_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sel_out_fifo
// Brief    : Self-checking bench for sel_out_fifo: vector table with hand
//            expected occupancy/overflow plus a data scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sel_out_fifo;

  logic        CLK = 1'b0;
  logic        RESET, FLUSH, IN_VALID, OUT_READY;
  logic [31:0] IN_DATA;
  logic [3:0]  IN_BE;
  logic        IN_READY, OUT_VALID, FULL, EMPTY, OVERFLOW;
  logic [31:0] OUT_DATA;
  logic [3:0]  OUT_BE;
  logic [2:0]  COUNT;

  always #5 CLK = ~CLK;

  sel_out_fifo #(.WIDTH(32), .DEPTH(4), .AW(2)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_BE(IN_BE), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_BE(OUT_BE), .OUT_READY(OUT_READY),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY), .OVERFLOW(OVERFLOW)
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic [3:0]  be;
    logic        ordy;
    int          ec;   // expected COUNT after the edge
    logic        eo;   // expected OVERFLOW after the edge
  } vec_t;

  vec_t        tbl[$];
  logic [35:0] sb[$];  // {be, masked data} in push order
  int          nvec = 0;
  int          nmis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mask(input logic [31:0] d, input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? d[8*i +: 8] : 8'h00;
    return m;
  endfunction

  function automatic void add(input logic fl, input logic iv, input logic [31:0] d,
                              input logic [3:0] be, input logic ordy, input int ec,
                              input logic eo);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.be = be; v.ordy = ordy; v.ec = ec; v.eo = eo;
    tbl.push_back(v);
  endfunction

  // Status and head-of-queue checks, sampled away from the clock edge.
  task automatic chk_state(input string tag, input int ec, input logic eo);
    chk({tag, ".count"}, 32'(COUNT), 32'(ec));
    chk({tag, ".ovf"}, 32'(OVERFLOW), 32'(eo));
    chk({tag, ".full"}, 32'(FULL), 32'(ec == 4));
    chk({tag, ".empty"}, 32'(EMPTY), 32'(ec == 0));
    chk({tag, ".in_ready"}, 32'(IN_READY), 32'(ec != 4));
    if (sb.size() > 0) begin
      chk({tag, ".out_valid"}, 32'(OUT_VALID), 32'd1);
      chk({tag, ".out_data"}, OUT_DATA, sb[0][31:0]);
      chk({tag, ".out_be"}, 32'(OUT_BE), 32'(sb[0][35:32]));
    end else begin
      chk({tag, ".out_valid"}, 32'(OUT_VALID), 32'd0);
      chk({tag, ".out_data"}, OUT_DATA, 32'd0);
      chk({tag, ".out_be"}, 32'(OUT_BE), 32'd0);
    end
  endtask

  // Called 1 time unit after a rising edge; drives one cycle of stimulus.
  task automatic step(input vec_t v);
    int sz;
    FLUSH = v.fl; IN_VALID = v.iv; IN_DATA = v.d; IN_BE = v.be; OUT_READY = v.ordy;
    #3;
    sz = sb.size();
    if (v.fl) begin
      sb.delete();
    end else begin
      if (v.ordy && sz > 0) void'(sb.pop_front());
      if (v.iv && sz < 4) sb.push_back({v.be, mask(v.d, v.be)});
    end
    @(posedge CLK); #1;
    chk_state("vec", v.ec, v.eo);
  endtask

  initial begin
    vec_t v;
    RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    IN_DATA = '0; IN_BE = '0;

    //        fl iv data           be     rdy cnt ovf
    add(1'b0, 1'b1, 32'h0000ABCD, 4'h1, 1'b0, 1, 1'b0);  // single push, masked
    add(1'b0, 1'b0, 32'h0,        4'h0, 1'b1, 0, 1'b0);  // pop it
    add(1'b0, 1'b1, 32'h00000FFF, 4'hF, 1'b0, 1, 1'b0);  // fill
    add(1'b0, 1'b1, 32'h11111111, 4'hF, 1'b0, 2, 1'b0);
    add(1'b0, 1'b1, 32'h22222222, 4'hF, 1'b0, 3, 1'b0);
    add(1'b0, 1'b1, 32'h33333333, 4'hF, 1'b0, 4, 1'b0);
    add(1'b0, 1'b1, 32'h44444444, 4'hF, 1'b0, 4, 1'b1);  // rejected, overflow
    add(1'b0, 1'b0, 32'h0,        4'h0, 1'b1, 3, 1'b1);  // drain
    add(1'b0, 1'b0, 32'h0,        4'h0, 1'b1, 2, 1'b1);
    add(1'b0, 1'b0, 32'h0,        4'h0, 1'b1, 1, 1'b1);
    add(1'b0, 1'b0, 32'h0,        4'h0, 1'b1, 0, 1'b1);
    add(1'b1, 1'b1, 32'h55555555, 4'hF, 1'b0, 0, 1'b0);  // flush drops push, clears ovf
    add(1'b0, 1'b1, 32'hA1B2C3D4, 4'hA, 1'b1, 1, 1'b0);  // ready on empty: no pop
    add(1'b0, 1'b1, 32'h12345678, 4'h6, 1'b0, 2, 1'b0);
    for (int i = 1; i <= 8; i++)                          // concurrent push/pop
      add(1'b0, 1'b1, 32'(i), 4'hF, 1'b1, 2, 1'b0);
    add(1'b0, 1'b0, 32'h0,        4'h0, 1'b1, 1, 1'b0);
    add(1'b0, 1'b0, 32'h0,        4'h0, 1'b1, 0, 1'b0);
    for (int i = 1; i <= 4; i++)
      add(1'b0, 1'b1, 32'hC0DE0000 | 32'(i), 4'hF, 1'b0, i, 1'b0);
    add(1'b0, 1'b1, 32'h0000DEAD, 4'hF, 1'b1, 3, 1'b1);  // full: pop only, overflow
    add(1'b1, 1'b1, 32'h66666666, 4'hF, 1'b1, 0, 1'b0);  // flush priority
    add(1'b0, 1'b0, 32'h0,        4'h0, 1'b1, 0, 1'b0);  // pop on empty
    add(1'b0, 1'b1, 32'h77777777, 4'hF, 1'b0, 1, 1'b0);  // two entries for reset test
    add(1'b0, 1'b1, 32'h88888888, 4'hC, 1'b0, 2, 1'b0);

    // Reset then idle.
    repeat (2) @(posedge CLK);
    #4 RESET = 1'b0;
    @(posedge CLK); #1;
    chk_state("reset_idle", 0, 1'b0);

    foreach (tbl[k]) step(tbl[k]);

    // Asynchronous reset between edges with two entries held.
    IN_VALID = 1'b0; OUT_READY = 1'b0; FLUSH = 1'b0;
    #2 RESET = 1'b1;
    #1;
    sb.delete();
    chk_state("async_rst", 0, 1'b0);
    @(posedge CLK); #1;
    chk_state("rst_held", 0, 1'b0);
    #3 RESET = 1'b0;
    @(posedge CLK); #1;

    // Resume after release: one-cycle fall-through latency.
    v.fl = 1'b0; v.iv = 1'b1; v.d = 32'hABCD; v.be = 4'hF; v.ordy = 1'b0; v.ec = 1; v.eo = 1'b0;
    step(v);
    chk("post_rst_data", OUT_DATA, 32'h0000ABCD);
    v.iv = 1'b0; v.ordy = 1'b1; v.ec = 0;
    step(v);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sel_out_fifo.md
Name: sel_out_fifo

Overview:
- Downstream stage of the byte selector: captures each assembled 32-bit selector result and its 4-bit lane-enable mask.
- Buffers results in a small FIFO and hands them to the consumer over a valid/ready handshake.
- Decouples selector timing from a consumer that may stall.
- Masks disabled byte lanes to zero on write and reports occupancy and overflow status.

Parameters:
- WIDTH, 32, data word width in bits (multiple of 8).
- DEPTH, 4, number of FIFO entries (power of two, minimum 2).
- AW, 2, pointer width, equal to log2(DEPTH).

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- FLUSH  input  1  synchronous clear of all entries.
- IN_VALID  input  1  selector result present this cycle.
- IN_DATA  input  WIDTH  selector result word.
- IN_BE  input  WIDTH/8  lane enables (bit i covers byte i).
- IN_READY  output  1  FIFO can accept a word this cycle.
- OUT_VALID  output  1  head entry available.
- OUT_DATA  output  WIDTH  head entry data, already lane-masked.
- OUT_BE  output  WIDTH/8  head entry lane enables.
- OUT_READY  input  1  consumer takes head this cycle.
- COUNT  output  AW+1  current occupancy, 0..DEPTH.
- FULL  output  1  COUNT == DEPTH.
- EMPTY  output  1  COUNT == 0.
- OVERFLOW  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (RESET=1, asynchronous):
  - Read and write pointers and COUNT go to 0.
  - OVERFLOW=0, IN_READY=1, OUT_VALID=0, EMPTY=1, FULL=0.
  - OUT_DATA=0, OUT_BE=0.
  - Storage contents are don't-care.
- Push: occurs when IN_VALID && IN_READY at a CLK edge.
  - The stored word has byte i = IN_DATA[8i+7:8i] if IN_BE[i], else 8'h00.
  - IN_BE is stored unchanged.
- Pop: occurs when OUT_VALID && OUT_READY at a CLK edge; the read pointer advances.
- IN_READY = !FULL. This is combinational from registered state only; there is no dependency on OUT_READY.
- Full: no push is accepted, even if a pop happens in the same cycle.
  - If IN_VALID=1 while FULL=1, OVERFLOW sets at that edge.
  - OVERFLOW holds until RESET or FLUSH.
- Empty: OUT_VALID=0, and OUT_DATA/OUT_BE are forced to 0. Pop is impossible.
- First-word-fall-through: a word pushed at edge N appears on OUT_DATA with OUT_VALID=1 after edge N, i.e. 1-cycle latency.
- OUT_DATA/OUT_BE are driven from the head entry. They stay stable while OUT_VALID=1 and OUT_READY=0.
- Simultaneous push and pop with 0 < COUNT < DEPTH: both happen and COUNT is unchanged.
- Pointers are AW bits and wrap modulo DEPTH. COUNT is kept as a separate AW+1-bit register.
  - COUNT never exceeds DEPTH and never underflows.
- FLUSH=1 at an edge:
  - Pointers and COUNT go to 0 and OVERFLOW clears.
  - Any push or pop in that same cycle is discarded.
  - FLUSH has priority over push and pop.
- Reset asserted mid-stream: all entries are lost immediately, without waiting for CLK.
  - Outputs show reset values while RESET=1.
  - Operation resumes at the first CLK edge after RESET deasserts.
- Ordering is strictly FIFO; words are never reordered or duplicated.

Test Plan:
- Reset then idle:
  - RESET=1 for 2 cycles, then 0 with IN_VALID=0 -> IN_READY=1, OUT_VALID=0, EMPTY=1, COUNT=0, OUT_DATA=0.
- Single push with masking:
  - IN_DATA=32'h0000ABCD, IN_BE=4'b0001 for 1 cycle, OUT_READY=0.
  - Next cycle -> OUT_VALID=1, OUT_DATA=32'h000000CD, OUT_BE=4'b0001, COUNT=1.
  - Then OUT_READY=1 for 1 cycle -> EMPTY=1.
- Fill and overflow:
  - Push 32'h00000FFF, 32'h11111111, 32'h22222222, 32'h33333333 (IN_BE=4'hF) with OUT_READY=0 -> FULL=1, IN_READY=0, COUNT=4.
  - Then push 32'h44444444 -> rejected, OVERFLOW=1.
  - Drain -> exactly the first four words, in order.
- Concurrent push/pop:
  - With COUNT=2, hold IN_VALID=1 and OUT_READY=1 for 8 cycles with incrementing data 1..8.
  - -> COUNT stays 2; outputs appear in push order; pointers wrap twice with no loss.
- Flush priority:
  - With COUNT=3 and OVERFLOW=1, assert FLUSH together with IN_VALID=1 and OUT_READY=1 -> next cycle COUNT=0, EMPTY=1, OVERFLOW=0, no new entry.
- Async reset mid-stream:
  - Assert RESET between clock edges while COUNT=2 -> OUT_VALID=0 and COUNT=0 before the next CLK edge.
  - After release, push 32'hABCD -> output 32'h0000ABCD one cycle later.
